// File: rtl/tone_defs_pkg.sv
// Shared definitions for the tone receive path: note period table, note code
// encoding and decoder state encoding.
package tone_defs;

    localparam int NUM_NOTES = 11;

    typedef enum logic [3:0] {
        NOTE_REST = 4'd0,
        NOTE_M1   = 4'd1,
        NOTE_M2   = 4'd2,
        NOTE_M3   = 4'd3,
        NOTE_M4   = 4'd4,
        NOTE_M5   = 4'd5,
        NOTE_M6   = 4'd6,
        NOTE_M7   = 4'd7,
        NOTE_H1   = 4'd8,
        NOTE_H2   = 4'd9,
        NOTE_H3   = 4'd10,
        NOTE_H4   = 4'd11
    } note_code_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_ACQ   = 2'd2;
    localparam logic [1:0] ST_LOCK  = 2'd3;

    // Nominal tone period in clk cycles for note codes 1..11.
    function automatic int note_period(input int code);
        case (code)
            1:       return 381680;
            2:       return 340136;
            3:       return 303030;
            4:       return 285714;
            5:       return 255102;
            6:       return 227273;
            7:       return 202429;
            8:       return 191204;
            9:       return 170357;
            10:      return 151745;
            11:      return 143061;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/tone_period_classifier.sv
// Matches a measured tone period against the note table; code_now is the note
// whose period lies within TOL cycles, or 0 when none does.
module tone_period_classifier
    import tone_defs::*;
#(
    parameter int CNT_W       = 20,
    parameter int TOL         = 2000,
    parameter int TABLE_SHIFT = 0
)(
    input  logic [CNT_W-1:0] period,
    output logic [3:0]       code_now
);

    logic [NUM_NOTES-1:0] hit;

    generate
        for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_cmp
            localparam int TK = note_period(gi + 1) >>> TABLE_SHIFT;
            logic signed [31:0] diff;
            assign diff    = int'(period) - TK;
            assign hit[gi] = (diff <= TOL) && (diff >= -TOL);
        end
    endgenerate

    // Table entries are spaced further apart than 2*TOL, so at most one hits.
    always_comb begin
        code_now = NOTE_REST;
        for (int k = 0; k < NUM_NOTES; k++) begin
            if (hit[k]) code_now = 4'(k + 1);
        end
    end

endmodule

// File: rtl/tone_decoder.sv
// Tone line receiver: measures rise-to-rise periods, locks onto notes and emits one
// event per played note. Define REST_REPORT_EN to also report silence after a note.
module tone_decoder
    import tone_defs::*;
#(
    parameter int CNT_W       = 20,
    parameter int TOL         = 2000,
    parameter int SILENCE_CYC = 600000,
    parameter int MIN_PERIODS = 4,
    parameter int TABLE_SHIFT = 0     // >0 scales the note table down (simulation only)
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        tone_in,
    output logic        note_valid,
    output logic [3:0]  note_code,
    output logic [15:0] note_len,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SILENCE_CYC - 1);
    localparam logic [15:0]      MIN_LEN = 16'(MIN_PERIODS);
    localparam logic [15:0]      LEN_MAX = 16'hFFFF;

    logic             sync1_reg, sync2_reg, prev_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       state_reg, state_next;
    logic [3:0]       cand_reg, cand_next;
    logic [15:0]      mcnt_reg, mcnt_next;
    logic [15:0]      len_reg, len_next;
    logic             note_valid_reg, busy_reg;
    logic [3:0]       note_code_reg;
    logic [15:0]      note_len_reg;
`ifdef REST_REPORT_EN
    logic             rest_active_reg, rest_active_next;
    logic [15:0]      rest_cnt_reg, rest_cnt_next;
`endif

    logic             rise, timeout, emit;
    logic [CNT_W-1:0] period;
    logic [3:0]       code_now, emit_code;
    logic [15:0]      emit_len;

    assign rise    = sync2_reg & ~prev_reg;
    assign timeout = (cnt_reg == CNT_MAX) & ~rise;
    assign period  = cnt_reg + CNT_W'(1);

    tone_period_classifier #(
        .CNT_W       (CNT_W),
        .TOL         (TOL),
        .TABLE_SHIFT (TABLE_SHIFT)
    ) u_classifier (
        .period   (period),
        .code_now (code_now)
    );

    // With rest reporting the counter restarts on each timeout so silence is
    // measured in whole windows; otherwise it simply parks at its maximum.
    always_comb begin
        cnt_next = cnt_reg;
        if (rise) begin
            cnt_next = '0;
`ifdef REST_REPORT_EN
        end else if (timeout) begin
            cnt_next = '0;
`endif
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        cand_next  = cand_reg;
        mcnt_next  = mcnt_reg;
        len_next   = len_reg;
        emit       = 1'b0;
        emit_code  = cand_reg;
        emit_len   = len_reg;
`ifdef REST_REPORT_EN
        rest_active_next = rest_active_reg;
        rest_cnt_next    = rest_cnt_reg;
`endif
        if (timeout) begin
            state_next = ST_IDLE;
            if (state_reg == ST_LOCK) begin
                emit = 1'b1;
`ifdef REST_REPORT_EN
                rest_active_next = 1'b1;
                rest_cnt_next    = 16'd1;
            end else if (state_reg == ST_IDLE && rest_active_reg && rest_cnt_reg != LEN_MAX) begin
                rest_cnt_next = rest_cnt_reg + 16'd1;
`endif
            end
        end else if (rise) begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_ARMED;
`ifdef REST_REPORT_EN
                    if (rest_active_reg) begin
                        emit             = 1'b1;
                        emit_code        = NOTE_REST;
                        emit_len         = rest_cnt_reg;
                        rest_active_next = 1'b0;
                    end
`endif
                end
                ST_ARMED: begin
                    if (code_now != NOTE_REST) begin
                        state_next = ST_ACQ;
                        cand_next  = code_now;
                        mcnt_next  = 16'd1;
                    end
                end
                ST_ACQ: begin
                    if (code_now == NOTE_REST) begin
                        state_next = ST_ARMED;
                    end else if (code_now == cand_reg) begin
                        mcnt_next = mcnt_reg + 16'd1;
                        if (mcnt_reg + 16'd1 == MIN_LEN) begin
                            state_next = ST_LOCK;
                            len_next   = MIN_LEN;
                        end
                    end else begin
                        cand_next = code_now;
                        mcnt_next = 16'd1;
                    end
                end
                default: begin
                    if (code_now == cand_reg) begin
                        if (len_reg != LEN_MAX) len_next = len_reg + 16'd1;
                    end else begin
                        emit = 1'b1;
                        if (code_now == NOTE_REST) begin
                            state_next = ST_ARMED;
                        end else begin
                            state_next = ST_ACQ;
                            cand_next  = code_now;
                            mcnt_next  = 16'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg      <= 1'b1;
            sync2_reg      <= 1'b1;
            prev_reg       <= 1'b1;
            cnt_reg        <= '0;
            state_reg      <= ST_IDLE;
            cand_reg       <= '0;
            mcnt_reg       <= '0;
            len_reg        <= '0;
            note_valid_reg <= 1'b0;
            note_code_reg  <= '0;
            note_len_reg   <= '0;
            busy_reg       <= 1'b0;
`ifdef REST_REPORT_EN
            rest_active_reg <= 1'b0;
            rest_cnt_reg    <= '0;
`endif
        end else begin
            sync1_reg      <= tone_in;
            sync2_reg      <= sync1_reg;
            prev_reg       <= sync2_reg;
            cnt_reg        <= cnt_next;
            state_reg      <= state_next;
            cand_reg       <= cand_next;
            mcnt_reg       <= mcnt_next;
            len_reg        <= len_next;
            note_valid_reg <= emit;
            if (emit) begin
                note_code_reg <= emit_code;
                note_len_reg  <= emit_len;
            end
            busy_reg       <= (state_next == ST_LOCK);
`ifdef REST_REPORT_EN
            rest_active_reg <= rest_active_next;
            rest_cnt_reg    <= rest_cnt_next;
`endif
        end
    end

    assign note_valid = note_valid_reg;
    assign note_code  = note_code_reg;
    assign note_len   = note_len_reg;
    assign busy       = busy_reg;

endmodule
